// File: rtl/inter_arbiter.sv
// inter_arbiter: round-robin sharing of one inter stream engine among num_req requesters, with results routed back by tag.
// Latency: zero-cycle combinational pass-through on issue and return; grant pointer and tag FIFO update on the next clk edge.
// Backpressure: s1i_rdy stalls only the granted requester; the head-tag owner's resp_rdy drives s1o_rdy; issue stops at fifo_depth in flight.
//
// Ports:
//   clk, rst_n             - clock, asynchronous active-low reset
//   req_valid/rdy/data     - per-requester input streams (requester i at data bits [i*num_bits +: num_bits])
//   resp_valid/rdy, data   - per-requester result streams, shared data bus, at most one valid bit set
//   s1i_valid/rdy/data     - merged stream into the engine
//   s1o_valid/rdy/data     - result stream from the engine, returned in issue order
//   inflight               - tag FIFO occupancy
//   proto_err              - sticky: engine produced a result with no outstanding tag
module inter_arbiter #(
    parameter int num_bits   = 127,
    parameter int num_req    = 4,
    parameter int fifo_depth = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [num_req-1:0]            req_valid,
    output logic [num_req-1:0]            req_rdy,
    input  logic [num_req*num_bits-1:0]   req_data,
    output logic [num_req-1:0]            resp_valid,
    input  logic [num_req-1:0]            resp_rdy,
    output logic [num_bits-1:0]           resp_data,
    output logic                          s1i_valid,
    input  logic                          s1i_rdy,
    output logic [num_bits-1:0]           s1i_data,
    input  logic                          s1o_valid,
    output logic                          s1o_rdy,
    input  logic [num_bits-1:0]           s1o_data,
    output logic [$clog2(fifo_depth):0]   inflight,
    output logic                          proto_err
);

    localparam int PW = $clog2(num_req);
    localparam int AW = $clog2(fifo_depth);
    localparam int CW = AW + 1;
    localparam logic [PW-1:0] last_idx  = PW'(num_req - 1);
    localparam logic [CW-1:0] depth_cnt = CW'(fifo_depth);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PW-1:0] rr_ptr;
    logic [CW-1:0] wr_ptr;
    logic [CW-1:0] rd_ptr;
    logic [PW-1:0] tag_mem [fifo_depth];

    // ------------------------------------------------------------------
    // Issue path
    // ------------------------------------------------------------------
    logic [num_bits-1:0] req_arr [num_req];
    logic [PW-1:0]       grant;
    logic                any_v;
    logic                full;
    logic                empty;
    logic                push;
    logic                pop;
    logic [PW-1:0]       head;
    int unsigned         cand;

    for (genvar i = 0; i < num_req; i++) begin : g_unpack
        assign req_arr[i] = req_data[i*num_bits +: num_bits];
    end

    // First valid requester at or after rr_ptr, wrapping modulo num_req.
    // The explicit subtract keeps the wrap correct when num_req is not a power of 2.
    always_comb begin
        grant = rr_ptr;
        cand  = 0;
        for (int k = num_req - 1; k >= 0; k--) begin
            cand = 32'(rr_ptr) + 32'(k);
            if (cand >= 32'(num_req)) begin
                cand = cand - 32'(num_req);
            end
            // Scanning from the far end down lets the nearest valid index win last.
            if (req_valid[cand[PW-1:0]]) begin
                grant = cand[PW-1:0];
            end
        end
    end

    assign any_v = |req_valid;
    assign full  = (inflight == depth_cnt);
    assign empty = (inflight == '0);

    // rst_n gating keeps issue-side outputs quiet while reset is held.
    assign s1i_valid = rst_n & any_v & ~full;
    assign s1i_data  = req_arr[grant];
    assign push      = s1i_valid & s1i_rdy;

    always_comb begin
        req_rdy        = '0;
        req_rdy[grant] = push;
    end

    // ------------------------------------------------------------------
    // Return path
    // ------------------------------------------------------------------
    assign head      = tag_mem[rd_ptr[AW-1:0]];
    assign resp_data = s1o_data;

    // A result arriving with no outstanding tag is never accepted or routed.
    assign s1o_rdy = ~empty & resp_rdy[head];
    assign pop     = s1o_valid & s1o_rdy;

    always_comb begin
        resp_valid       = '0;
        resp_valid[head] = s1o_valid & ~empty;
    end

    // Pointers are one bit wider than the index so full and empty stay distinct.
    assign inflight = wr_ptr - rd_ptr;

    // ------------------------------------------------------------------
    // Sequential update
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            proto_err <= 1'b0;
        end else begin
            if (push) begin
                rr_ptr <= (grant == last_idx) ? '0 : grant + 1'b1;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (s1o_valid & empty) begin
                proto_err <= 1'b1;
            end
        end
    end

    // Tag storage needs no reset: entries are only read behind a valid push.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr[AW-1:0]] <= grant;
        end
    end

endmodule

// File: tb/tb_inter_arbiter.sv
module tb_inter_arbiter;

    localparam int NB = 127;
    localparam int NR = 4;
    localparam int FD = 8;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NR-1:0]        req_valid;
    logic [NR-1:0]        req_rdy;
    logic [NR*NB-1:0]     req_data;
    logic [NR-1:0]        resp_valid;
    logic [NR-1:0]        resp_rdy;
    logic [NB-1:0]        resp_data;
    logic                 s1i_valid;
    logic                 s1i_rdy;
    logic [NB-1:0]        s1i_data;
    logic                 s1o_valid;
    logic                 s1o_rdy;
    logic [NB-1:0]        s1o_data;
    logic [3:0]           inflight;
    logic                 proto_err;

    inter_arbiter #(.num_bits(NB), .num_req(NR), .fifo_depth(FD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_rdy    (req_rdy),
        .req_data   (req_data),
        .resp_valid (resp_valid),
        .resp_rdy   (resp_rdy),
        .resp_data  (resp_data),
        .s1i_valid  (s1i_valid),
        .s1i_rdy    (s1i_rdy),
        .s1i_data   (s1i_data),
        .s1o_valid  (s1o_valid),
        .s1o_rdy    (s1o_rdy),
        .s1o_data   (s1o_data),
        .inflight   (inflight),
        .proto_err  (proto_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: next search start, issuer queue, engine queue, sticky error.
    int            mptr = 0;
    logic          merr = 1'b0;
    int            tq[$];
    logic [NB-1:0] eq[$];
    logic [NB-1:0] reqd [NR];

    // Per-step observations of the DUT.
    int            dut_grant;
    logic          issued;
    logic          popped;
    logic [NR-1:0] rv_obs;
    logic [NB-1:0] rd_obs;
    logic [NB-1:0] si_obs;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NB-1:0] rnd127();
        logic [127:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        return t[NB-1:0];
    endfunction

    task automatic rnd_data();
        for (int i = 0; i < NR; i++) reqd[i] = rnd127();
    endtask

    // Round-robin rule: first valid index searching upward from mptr, wrapping.
    function automatic int pick(input logic [NR-1:0] rv);
        for (int k = 0; k < NR; k++) begin
            if (rv[(mptr + k) % NR]) return (mptr + k) % NR;
        end
        return -1;
    endfunction

    task automatic model_clear();
        tq.delete();
        eq.delete();
        mptr = 0;
        merr = 1'b0;
    endtask

    // One clock cycle: drive after the edge, check mid-cycle, advance the model.
    task automatic step(input logic [NR-1:0] rv, input logic ir, input logic ov,
                        input logic spur, input logic [NR-1:0] rr);
        int            g;
        int            h;
        logic          vld_m;
        logic          or_m;
        logic          pop_m;
        logic [NR-1:0] exp_rdy;
        logic [NR-1:0] exp_rv;
        #1;
        req_valid = rv;
        for (int i = 0; i < NR; i++) req_data[i*NB +: NB] = reqd[i];
        s1i_rdy   = ir;
        s1o_valid = spur | (ov && (eq.size() > 0));
        s1o_data  = (eq.size() > 0) ? eq[0] + 1'b1 : rnd127();
        resp_rdy  = rr;
        #2;
        chk("inflight", inflight, tq.size());
        chk("proto_err", proto_err, merr);
        g     = pick(rv);
        vld_m = (g >= 0) && (tq.size() < FD);
        chk("s1i_valid", s1i_valid, vld_m);
        exp_rdy = '0;
        if (vld_m && ir) exp_rdy[g] = 1'b1;
        chk("req_rdy", req_rdy, exp_rdy);
        if (vld_m) chk("s1i_data", s1i_data, reqd[g]);
        exp_rv = '0;
        or_m   = 1'b0;
        h      = -1;
        if (tq.size() > 0) begin
            h = tq[0];
            if (s1o_valid) exp_rv[h] = 1'b1;
            or_m = rr[h];
        end
        chk("resp_valid", resp_valid, exp_rv);
        chk("s1o_rdy", s1o_rdy, or_m);
        if (s1o_valid) chk("resp_data", resp_data, s1o_data);

        dut_grant = -1;
        for (int i = 0; i < NR; i++) if (req_rdy[i]) dut_grant = i;
        issued = s1i_valid & s1i_rdy;
        popped = s1o_valid & s1o_rdy;
        rv_obs = resp_valid;
        rd_obs = resp_data;
        si_obs = s1i_data;

        pop_m = s1o_valid && (h >= 0) && or_m;
        if (s1o_valid && (tq.size() == 0)) merr = 1'b1;
        if (pop_m) begin
            void'(tq.pop_front());
            void'(eq.pop_front());
        end
        if (vld_m && ir) begin
            tq.push_back(g);
            eq.push_back(reqd[g]);
            mptr = (g + 1) % NR;
        end
        @(posedge clk);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '1;
        s1i_rdy   = 1'b1;
        s1o_valid = 1'b0;
        resp_rdy  = '1;
        repeat (3) begin
            @(posedge clk);
            #2;
            chk("rst_req_rdy", req_rdy, 0);
            chk("rst_s1i_valid", s1i_valid, 0);
            chk("rst_inflight", inflight, 0);
            chk("rst_proto_err", proto_err, 0);
            chk("rst_resp_valid", resp_valid, 0);
            chk("rst_s1o_rdy", s1o_rdy, 0);
        end
        req_valid = '0;
        rst_n     = 1'b1;
        model_clear();
        @(posedge clk);
        #1;
        chk("post_rst_req_rdy", req_rdy, 0);
        chk("post_rst_s1i_valid", s1i_valid, 0);
        chk("post_rst_inflight", inflight, 0);
        chk("post_rst_proto_err", proto_err, 0);
    endtask

    initial begin
        logic [NB-1:0] d1;
        logic [NB-1:0] d1r;
        req_data = '0;
        s1o_data = '0;

        // Reset defaults, then a single beat from requester 2.
        do_reset();
        rnd_data();
        reqd[2] = 127'h15;
        step(4'b0100, 1'b1, 1'b0, 1'b0, 4'b1111);
        chk("t1_s1i_data", si_obs, 127'h15);
        chk("t1_grant", dut_grant, 2);
        step(4'b0000, 1'b0, 1'b1, 1'b0, 4'b1111);
        chk("t1_resp_valid", rv_obs, 4'b0100);
        chk("t1_pop", popped, 1'b1);

        // Round-robin fairness with everyone valid.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            rnd_data();
            step(4'b1111, 1'b1, 1'b1, 1'b0, 4'b1111);
            chk("rr_grant", dut_grant, i % NR);
        end
        for (int i = 0; i < 2; i++) step(4'b0000, 1'b0, 1'b1, 1'b0, 4'b1111);

        // FIFO full: no returns until 8 beats are in flight.
        do_reset();
        for (int i = 0; i < FD; i++) begin
            rnd_data();
            step(4'b1111, 1'b1, 1'b0, 1'b0, 4'b1111);
        end
        #1;
        chk("full_inflight", inflight, FD);
        chk("full_s1i_valid", s1i_valid, 1'b0);
        chk("full_req_rdy", req_rdy, 0);
        step(4'b1111, 1'b1, 1'b0, 1'b0, 4'b1111);
        chk("full_no_issue", issued, 1'b0);
        step(4'b1111, 1'b1, 1'b1, 1'b0, 4'b1111);
        chk("full_pop", popped, 1'b1);
        chk("full_no_bypass", issued, 1'b0);
        step(4'b1111, 1'b1, 1'b0, 1'b0, 4'b1111);
        chk("full_issue_after_free", issued, 1'b1);
        for (int i = 0; i < FD + 1; i++) step(4'b0000, 1'b0, 1'b1, 1'b0, 4'b1111);

        // Return backpressure on head tag 1.
        do_reset();
        rnd_data();
        d1  = reqd[1];
        d1r = d1 + 1'b1;
        step(4'b0010, 1'b1, 1'b0, 1'b0, 4'b1111);
        step(4'b0001, 1'b1, 1'b0, 1'b0, 4'b1111);
        for (int i = 0; i < 5; i++) begin
            step(4'b0000, 1'b0, 1'b1, 1'b0, 4'b1101);
            chk("bp_resp_valid", rv_obs, 4'b0010);
            chk("bp_data", rd_obs, d1r);
            chk("bp_no_pop", popped, 1'b0);
        end
        step(4'b0000, 1'b0, 1'b1, 1'b0, 4'b1111);
        chk("bp_pop", popped, 1'b1);
        step(4'b0000, 1'b0, 1'b1, 1'b0, 4'b1111);
        chk("bp_pop_tag0", rv_obs, 4'b0001);

        // Spurious result with nothing in flight.
        do_reset();
        step(4'b0000, 1'b0, 1'b0, 1'b1, 4'b1111);
        chk("spur_s1o_rdy", popped, 1'b0);
        chk("spur_resp_valid", rv_obs, 0);
        #1;
        chk("spur_err", proto_err, 1'b1);
        step(4'b0000, 1'b0, 1'b0, 1'b0, 4'b1111);
        step(4'b0000, 1'b0, 1'b0, 1'b0, 4'b1111);
        chk("spur_err_sticky", proto_err, 1'b1);

        // Asynchronous reset pulse with 3 beats in flight.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            rnd_data();
            step(4'b1111, 1'b1, 1'b0, 1'b0, 4'b1111);
        end
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_inflight", inflight, 0);
        chk("mid_rst_req_rdy", req_rdy, 0);
        #1;
        rst_n = 1'b1;
        model_clear();
        rnd_data();
        step(4'b1010, 1'b1, 1'b0, 1'b0, 4'b1111);
        chk("mid_rst_first_grant", dut_grant, 1);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            rnd_data();
            step(4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 2) != 0), 1'b0,
                 4'($urandom_range(0, 15) | $urandom_range(0, 15)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
